// File: rtl/nios_hps_system_baud_tickgen.sv
// Baud tick generator: divisor-period oversample tick plus a bit tick every OVERSAMPLE ticks.
// Optional build macro BAUDGEN_TICKCNT_EN adds a 32-bit tick_bit counter output (tick_count).
module nios_hps_system_baud_tickgen #(
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_RESET  = 0,
    localparam int OS_W      = $clog2(OVERSAMPLE)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] divisor,
    input  logic             enable,
    input  logic             restart,
    output logic             tick_os,
    output logic             tick_bit,
    output logic [OS_W-1:0]  os_phase,
    output logic [DIV_W-1:0] div_active
`ifdef BAUDGEN_TICKCNT_EN
    ,
    output logic [31:0]      tick_count
`endif
);

    localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RESET);
    localparam logic [OS_W-1:0]  PHASE_MAX = OS_W'(OVERSAMPLE - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [OS_W-1:0]  phase_q, phase_d;
    logic             tick_os_q, tick_os_d;
    logic             tick_bit_q, tick_bit_d;

    // Divisor is only sampled on restart or on the terminal edge, so periods never truncate.
    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        phase_d    = phase_q;
        tick_os_d  = 1'b0;
        tick_bit_d = 1'b0;
        if (restart) begin
            cnt_d   = divisor;
            div_d   = divisor;
            phase_d = '0;
        end else if (enable) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - DIV_W'(1);
            end else begin
                cnt_d     = divisor;
                div_d     = divisor;
                tick_os_d = 1'b1;
                if (phase_q == PHASE_MAX) begin
                    phase_d    = '0;
                    tick_bit_d = 1'b1;
                end else begin
                    phase_d = phase_q + OS_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= DIV_RST_V;
            div_q      <= DIV_RST_V;
            phase_q    <= '0;
            tick_os_q  <= 1'b0;
            tick_bit_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            tick_os_q  <= tick_os_d;
            tick_bit_q <= tick_bit_d;
        end
    end

    assign tick_os    = tick_os_q;
    assign tick_bit   = tick_bit_q;
    assign os_phase   = phase_q;
    assign div_active = div_q;

`ifdef BAUDGEN_TICKCNT_EN
    logic [31:0] tick_count_q, tick_count_d;

    always_comb begin
        tick_count_d = tick_count_q;
        if (restart)
            tick_count_d = '0;
        else if (tick_bit_d)
            tick_count_d = tick_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tick_count_q <= '0;
        else
            tick_count_q <= tick_count_d;
    end

    assign tick_count = tick_count_q;
`endif

endmodule

// File: tb/tb_nios_hps_system_baud_tickgen.sv
// Self-checking bench for nios_hps_system_baud_tickgen (DIV_W=16, OVERSAMPLE=16, DIV_RESET=0).
// Covers tick_count as well when built with BAUDGEN_TICKCNT_EN.
module tb_nios_hps_system_baud_tickgen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] divisor = 16'd0;
    logic        enable = 1'b0;
    logic        restart = 1'b0;
    logic        tick_os, tick_bit;
    logic [3:0]  os_phase;
    logic [15:0] div_active;
`ifdef BAUDGEN_TICKCNT_EN
    logic [31:0] tick_count;
`endif

    nios_hps_system_baud_tickgen #(.DIV_W(16), .OVERSAMPLE(16), .DIV_RESET(0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .divisor    (divisor),
        .enable     (enable),
        .restart    (restart),
        .tick_os    (tick_os),
        .tick_bit   (tick_bit),
        .os_phase   (os_phase),
        .div_active (div_active)
`ifdef BAUDGEN_TICKCNT_EN
        ,
        .tick_count (tick_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        t_os;
        logic        t_bit;
        logic [3:0]  ph;
        logic [15:0] da;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [15:0] div;
        int          cycles;
        int          exp_os;
        int          exp_bit;
        logic [3:0]  exp_ph;
    } vec_t;
    vec_t vecs[6];

    // Reference: enabled-edge count since the last restart, constant divisor over that span.
    int e_cnt = 0;
    int m_div = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic step(input logic en, input logic rs);
        enable  = en;
        restart = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_edge(input logic en, input logic rs);
        exp_t e;
        exp_t got;
        int   m;
        e.t_os = 1'b0;
        e.t_bit = 1'b0;
        if (rs) begin
            e_cnt = 0;
            m_div = int'(divisor);
        end else if (en) begin
            e_cnt++;
            e.t_os = ((e_cnt % (m_div + 1)) == 0);
        end
        m = e_cnt / (m_div + 1);
        e.ph = 4'(m % 16);
        e.t_bit = e.t_os && (m % 16 == 0);
        e.da = 16'(m_div);
        sb_q.push_back(e);
        step(en, rs);
        got = sb_q.pop_front();
        chk("sb_tick_os", {31'd0, tick_os}, {31'd0, got.t_os});
        chk("sb_tick_bit", {31'd0, tick_bit}, {31'd0, got.t_bit});
        chk("sb_os_phase", {28'd0, os_phase}, {28'd0, got.ph});
        chk("sb_div_active", {16'd0, div_active}, {16'd0, got.da});
    endtask

    // Plain stepping until tick_os; returns edges taken (bound+1 on timeout, flagged as a failure).
    task automatic edges_to_tick(input int bound, output int n);
        n = 0;
        do begin
            step(1'b1, 1'b0);
            n++;
        end while (!tick_os && n <= bound);
        if (!tick_os) chk("tick_timeout", 32'(n), 32'(bound));
    endtask

    initial begin
        int n_os, n_bit, n;
        vecs[0] = '{div: 16'd3,  cycles: 128, exp_os: 32, exp_bit: 2, exp_ph: 4'd0};
        vecs[1] = '{div: 16'd0,  cycles: 48,  exp_os: 48, exp_bit: 3, exp_ph: 4'd0};
        vecs[2] = '{div: 16'd1,  cycles: 64,  exp_os: 32, exp_bit: 2, exp_ph: 4'd0};
        vecs[3] = '{div: 16'd7,  cycles: 256, exp_os: 32, exp_bit: 2, exp_ph: 4'd0};
        vecs[4] = '{div: 16'd15, cycles: 300, exp_os: 18, exp_bit: 1, exp_ph: 4'd2};
        vecs[5] = '{div: 16'd2,  cycles: 47,  exp_os: 15, exp_bit: 0, exp_ph: 4'd15};

        // Reset state
        divisor = 16'd5;
        enable  = 1'b1;
        #1;
        chk("rst_tick_os", {31'd0, tick_os}, 32'd0);
        chk("rst_tick_bit", {31'd0, tick_bit}, 32'd0);
        chk("rst_os_phase", {28'd0, os_phase}, 32'd0);
        chk("rst_div_active", {16'd0, div_active}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_div", {16'd0, div_active}, 32'd0);
        reset_n = 1'b1;

        // Table-driven runs at constant divisor
        foreach (vecs[i]) begin
            divisor = vecs[i].div;
            drive_edge(1'b1, 1'b1);
            n_os = 0;
            n_bit = 0;
            for (int c = 0; c < vecs[i].cycles; c++) begin
                drive_edge(1'b1, 1'b0);
                if (tick_os) n_os++;
                if (tick_bit) n_bit++;
            end
            chk("vec_os_count", 32'(n_os), 32'(vecs[i].exp_os));
            chk("vec_bit_count", 32'(n_bit), 32'(vecs[i].exp_bit));
            chk("vec_end_phase", {28'd0, os_phase}, {28'd0, vecs[i].exp_ph});
            chk("vec_div_active", {16'd0, div_active}, {16'd0, vecs[i].div});
        end

        // Divisor change 3 -> 9 one clock after a tick: old period completes first
        divisor = 16'd3;
        step(1'b1, 1'b1);
        edges_to_tick(20, n);
        chk("chg_first_gap", 32'(n), 32'd4);
        divisor = 16'd9;
        n = 0;
        do begin
            step(1'b1, 1'b0);
            n++;
            if (n == 3) chk("chg_div_old", {16'd0, div_active}, 32'd3);
        end while (!tick_os && n <= 30);
        chk("chg_old_period", 32'(n), 32'd4);
        chk("chg_div_new", {16'd0, div_active}, 32'd9);
        edges_to_tick(30, n);
        chk("chg_new_period", 32'(n), 32'd10);

        // Freeze 5 cycles mid-period at divisor 3
        divisor = 16'd3;
        drive_edge(1'b1, 1'b1);
        n_os = 0;
        n_bit = 0;
        for (int c = 0; c < 4; c++) drive_edge(1'b1, 1'b0);
        if (tick_os) n_os++;
        n = 0;
        for (int c = 0; c < 2; c++) begin drive_edge(1'b1, 1'b0); n++; end
        for (int c = 0; c < 5; c++) begin drive_edge(1'b0, 1'b0); n++; end
        chk("frz_phase_held", {28'd0, os_phase}, 32'd1);
        do begin
            drive_edge(1'b1, 1'b0);
            n++;
        end while (!tick_os && n <= 30);
        chk("frz_spacing", 32'(n), 32'd9);
        n_os++;
        for (int c = 0; c < 400 && n_os < 64; c++) begin
            drive_edge(1'b1, 1'b0);
            if (tick_os) n_os++;
            if (tick_bit) n_bit++;
        end
        chk("frz_os_total", 32'(n_os), 32'd64);
        chk("frz_bit_total", 32'(n_bit), 32'd4);

        // Restart at os_phase 7, then restart landing on a terminal edge
        drive_edge(1'b1, 1'b1);
        n = 0;
        do begin
            drive_edge(1'b1, 1'b0);
            n++;
        end while (os_phase != 4'd7 && n < 100);
        chk("rs_reach_ph7", {28'd0, os_phase}, 32'd7);
        drive_edge(1'b1, 1'b0);
        drive_edge(1'b1, 1'b1);
        chk("rs_phase_zero", {28'd0, os_phase}, 32'd0);
        chk("rs_tick_zero", {31'd0, tick_os}, 32'd0);
        n = 0;
        do begin
            drive_edge(1'b1, 1'b0);
            n++;
        end while (!tick_os && n <= 20);
        chk("rs_next_tick", 32'(n), 32'd4);
        for (int c = 0; c < 3; c++) drive_edge(1'b1, 1'b0);
        drive_edge(1'b1, 1'b1);
        chk("rs_term_no_tick", {31'd0, tick_os}, 32'd0);
        chk("rs_term_phase", {28'd0, os_phase}, 32'd0);

        // Asynchronous reset between edges, right after a tick
        edges_to_tick(20, n);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_tick_os", {31'd0, tick_os}, 32'd0);
        chk("arst_os_phase", {28'd0, os_phase}, 32'd0);
        chk("arst_div_active", {16'd0, div_active}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

`ifdef BAUDGEN_TICKCNT_EN
        chk("cnt_after_rst", tick_count, 32'd0);
        divisor = 16'd0;
        drive_edge(1'b1, 1'b1);
        for (int c = 0; c < 80; c++) drive_edge(1'b1, 1'b0);
        chk("cnt_five_bits", tick_count, 32'd5);
        drive_edge(1'b1, 1'b1);
        chk("cnt_restart_clr", tick_count, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1);
    end

endmodule
